// File: rtl/freq_div_ratio_sched_pkg.sv
// Shared definitions for the ratio-scheduled clock-enable divider.
//   CW_DEF      : default ratio/counter width
//   DEF_DIV_DEF : default ratio in effect after reset
//   state_e     : scheduler FSM states
package freq_div_ratio_sched_pkg;

  localparam int CW_DEF      = 7;
  localparam int DEF_DIV_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    PEND      = 2'd2,
    IDLE_PEND = 2'd3
  } state_e;

  // The period counter only advances in these states.
  function automatic logic is_running(input state_e s);
    return (s == RUN) || (s == PEND);
  endfunction

endpackage

// File: rtl/freq_div_ratio_sched_rr_arbiter.sv
// Round-robin arbiter for ratio-change requests.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : per-requester request (already masked by the caller)
//   advance_i     : the current winner is consumed; move priority past it
//   gnt_o         : one-hot winner (combinational)
//   idx_o         : binary index of the winner
//   valid_o       : some requester is asserting
module freq_div_ratio_sched_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    advance_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    valid_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  function automatic int rot(input int p, input int i);
    return (p + i) % NREQ;
  endfunction

  // Search starts at ptr_q, the requester after the last one consumed.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[rot(int'(ptr_q), i)]) begin
        found = 1'b1;
        gnt_o[rot(int'(ptr_q), i)] = 1'b1;
        idx_o = IW'(rot(int'(ptr_q), i));
      end
    end
  end

  assign valid_o = found;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (idx_o == IW'(NREQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/freq_div_ratio_sched.sv
// Programmable clock-enable divider whose ratio is shared by NREQ clients.
// Ratio changes are arbitrated round-robin, held one deep, and applied only
// at a period boundary so no runt period is ever produced.
//   clk_i, rst_ni : clock, async active-low reset
//   en_i          : 1 = divider running
//   req_i/div_in_i: per-requester ratio-change request and requested ratio
//   gnt_o, err_o  : 1-cycle service pulse (err_o when ratio 0 was rejected)
//   tick_o        : last cycle of each divided period
//   clkout_o      : divided clock, toggles once per tick
//   cur_div_o     : ratio in effect
//   busy_o        : an update is pending
//
// state     | meaning
// IDLE      | stopped, nothing pending
// RUN       | counting, nothing pending, arbiter live
// PEND      | counting, update waits for the end of the period
// IDLE_PEND | stopped, update applied on the next edge
module freq_div_ratio_sched
  import freq_div_ratio_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CW      = CW_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*CW-1:0] div_in_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               err_o,
  output logic               tick_o,
  output logic               clkout_o,
  output logic [CW-1:0]      cur_div_o,
  output logic               busy_o
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   cur_div_q, cur_div_d;
  logic [CW-1:0]   pend_div_q, pend_div_d;
  logic [IW-1:0]   pend_id_q, pend_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            err_q, err_d;
  logic            clkout_q;

  logic            tick;
  logic            capture;
  logic            apply;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  assign tick = is_running(state_q) && (count_q == cur_div_q);

  // A requester still high during its own gnt cycle is masked for that cycle.
  freq_div_ratio_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i & ~gnt_q),
    .advance_i (capture),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  assign capture = arb_valid && ((state_q == IDLE) || (state_q == RUN));
  assign apply   = ((state_q == PEND) && tick) || (state_q == IDLE_PEND);

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_id_d  = pend_id_q;
    gnt_d      = '0;
    err_d      = 1'b0;

    if (capture) begin
      pend_div_d = div_in_i[int'(arb_idx)*CW +: CW];
      pend_id_d  = arb_idx;
    end

    if (apply) begin
      gnt_d = NREQ'(1) << pend_id_q;
      err_d = (pend_div_q == '0);
      if (pend_div_q != '0) cur_div_d = pend_div_q;
    end

    // Wrap on tick, and restart from 1 whenever stopped or stopping.
    if (is_running(state_q) && en_i && !tick) count_d = count_q + 1'b1;
    else                                      count_d = CW'(1);

    case (state_q)
      IDLE, RUN: begin
        if (capture) state_d = en_i ? PEND : IDLE_PEND;
        else         state_d = en_i ? RUN  : IDLE;
      end
      PEND: begin
        if (tick) state_d = en_i ? RUN  : IDLE;
        else      state_d = en_i ? PEND : IDLE_PEND;
      end
      IDLE_PEND: state_d = en_i ? RUN : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      count_q    <= CW'(1);
      cur_div_q  <= CW'(DEF_DIV);
      pend_div_q <= '0;
      pend_id_q  <= '0;
      gnt_q      <= '0;
      err_q      <= 1'b0;
      clkout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_id_q  <= pend_id_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      if (tick) clkout_q <= ~clkout_q;
    end
  end

  assign gnt_o     = gnt_q;
  assign err_o     = err_q;
  assign tick_o    = tick;
  assign clkout_o  = clkout_q;
  assign cur_div_o = cur_div_q;
  assign busy_o    = (state_q == PEND) || (state_q == IDLE_PEND);

endmodule

// File: tb/tb_freq_div_ratio_sched.sv
module tb_freq_div_ratio_sched;

  localparam int NREQ = 4;
  localparam int CW   = 7;

  logic               clk_i    = 1'b0;
  logic               rst_ni   = 1'b0;
  logic               en_i     = 1'b0;
  logic [NREQ-1:0]    req_i    = '0;
  logic [NREQ*CW-1:0] div_in_i = '0;
  logic [NREQ-1:0]    gnt_o;
  logic               err_o;
  logic               tick_o;
  logic               clkout_o;
  logic [CW-1:0]      cur_div_o;
  logic               busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   id;
    logic err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  freq_div_ratio_sched #(.NREQ(NREQ), .CW(CW), .DEF_DIV(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .req_i     (req_i),
    .div_in_i  (div_in_i),
    .gnt_o     (gnt_o),
    .err_o     (err_o),
    .tick_o    (tick_o),
    .clkout_o  (clkout_o),
    .cur_div_o (cur_div_o),
    .busy_o    (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns cycles until the next tick, -1 if none within limit.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!tick_o && n < limit);
    if (!tick_o) n = -1;
  endtask

  task automatic wait_gnt(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (gnt_o == '0 && n < limit);
    if (gnt_o == '0) n = -1;
  endtask

  task automatic raise_req(input int id, input int ratio, input logic exp_err);
    exp_t e;
    div_in_i[id*CW +: CW] = CW'(ratio);
    req_i[id] = 1'b1;
    e.id  = id;
    e.err = exp_err;
    sb_q.push_back(e);
  endtask

  // Scoreboard: every gnt/err pulse must match the oldest expected service.
  always @(negedge clk_i) begin
    if (rst_ni && (gnt_o != '0 || err_o)) begin
      check("gnt_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("gnt_onehot", 32'(gnt_o), 32'd1 << e.id);
        check("gnt_err", 32'(err_o), 32'(e.err));
      end
    end
  end

  initial begin
    int   n;
    logic c;

    repeat (3) @(negedge clk_i);
    check("rst_cur_div", 32'(cur_div_o), 32'd8);
    check("rst_tick", 32'(tick_o), 32'd0);
    check("rst_clkout", 32'(clkout_o), 32'd0);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);

    // Free-running at the default ratio.
    rst_ni = 1'b1;
    en_i   = 1'b1;
    wait_tick(20, n);
    check("first_tick_def", 32'(n), 32'd8);
    check("busy_idle", 32'(busy_o), 32'd0);
    c = clkout_o;
    wait_tick(20, n);
    check("period_def", 32'(n), 32'd8);
    check("clkout_toggle", 32'(clkout_o), 32'(!c));

    // Ratio 5 requested by requester 1 at count 3.
    repeat (3) @(negedge clk_i);
    raise_req(1, 5, 1'b0);
    @(negedge clk_i);
    check("busy_after_capture", 32'(busy_o), 32'd1);
    wait_tick(20, n);
    check("tick_still_at_8", 32'(n), 32'd4);
    check("cur_div_before_apply", 32'(cur_div_o), 32'd8);
    wait_gnt(20, n);
    check("gnt1_latency", 32'(n), 32'd1);
    check("cur_div_5", 32'(cur_div_o), 32'd5);
    check("busy_drop", 32'(busy_o), 32'd0);
    req_i[1] = 1'b0;
    wait_tick(20, n);
    check("first_tick_5", 32'(n), 32'd4);
    wait_tick(20, n);
    check("period_5", 32'(n), 32'd5);

    // Zero ratio from requester 3 is rejected.
    raise_req(3, 0, 1'b1);
    wait_gnt(30, n);
    check("gnt3_latency", 32'(n), 32'd6);
    check("cur_div_kept", 32'(cur_div_o), 32'd5);
    req_i[3] = 1'b0;
    wait_tick(20, n);
    wait_tick(20, n);
    check("period_after_zero", 32'(n), 32'd5);

    // Two simultaneous requests; pointer wrapped to 0, so 0 then 2.
    raise_req(0, 3, 1'b0);
    raise_req(2, 6, 1'b0);
    wait_gnt(30, n);
    check("gnt0_latency", 32'(n), 32'd6);
    check("cur_div_3", 32'(cur_div_o), 32'd3);
    req_i[0] = 1'b0;
    wait_gnt(30, n);
    check("gnt2_latency", 32'(n), 32'd3);
    check("cur_div_6", 32'(cur_div_o), 32'd6);
    req_i[2] = 1'b0;
    wait_tick(20, n);
    wait_tick(20, n);
    check("period_6", 32'(n), 32'd6);

    // Stop at count 4, then change ratio while stopped.
    repeat (4) @(negedge clk_i);
    c    = clkout_o;
    en_i = 1'b0;
    @(negedge clk_i);
    check("stopped_tick", 32'(tick_o), 32'd0);
    raise_req(1, 2, 1'b0);
    wait_gnt(20, n);
    check("gnt_stopped_latency", 32'(n), 32'd2);
    check("cur_div_2", 32'(cur_div_o), 32'd2);
    check("clkout_held", 32'(clkout_o), 32'(c));
    check("stopped_no_tick", 32'(tick_o), 32'd0);
    req_i[1] = 1'b0;
    en_i     = 1'b1;
    wait_tick(20, n);
    check("restart_tick", 32'(n), 32'd2);

    // Reset while an update is pending: it is dropped without a gnt.
    div_in_i[0*CW +: CW] = CW'(9);
    req_i[0] = 1'b1;
    @(negedge clk_i);
    check("busy_before_rst", 32'(busy_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_cur_div", 32'(cur_div_o), 32'd8);
    check("rst_mid_clkout", 32'(clkout_o), 32'd0);
    check("rst_mid_gnt", 32'(gnt_o), 32'd0);
    req_i[0] = 1'b0;
    en_i     = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    en_i   = 1'b1;
    wait_tick(20, n);
    check("post_rst_tick", 32'(n), 32'd8);
    check("post_rst_cur_div", 32'(cur_div_o), 32'd8);
    repeat (20) @(negedge clk_i);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
